writeback_unit: RTL
===================

# writeback_unit

Writeback end of the register-file interface: the decode stage reads rs1/rs2 and this block produces the single register-file write port (rd, data, enable). It selects the result source, waits for variable-latency load data with a two-state FSM and a stall output, and aligns/sign-extends loads. All writes are registered, so a retiring instruction's write lands one cycle after it completes.

## Interface
- XLEN, 32, datapath width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- issue_i  in  1  an instruction is presented this cycle
- instr_type_i  in  3  `TYPER/`TYPEI/`TYPES/`TYPEB/`TYPEU/`TYPEJ from define.v
- rd_i  in  5  destination register
- wb_sel_i  in  2  0 ALU, 1 LOAD, 2 PC+4, 3 IMM
- load_funct3_i  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- alu_result_i  in  XLEN  execute result
- pc_i  in  XLEN  instruction PC
- imm_i  in  XLEN  immediate (LUI)
- mem_addr_lo_i  in  2  load byte address [1:0]
- mem_rdata_i  in  XLEN  data-memory read word
- mem_rvalid_i  in  1  mem_rdata_i valid this cycle
- stall_o  out  1  hold PC/fetch; combinational
- rf_we_o  out  1  register-file write enable, registered
- rf_waddr_o  out  5  write address, registered
- rf_wdata_o  out  XLEN  write data, registered
- retire_o  out  1  one-cycle pulse per completed instruction, registered

## Operation
- writes_rd = instr_type in {R, I, U, J} and rd_i != 0. S/B types and rd=0 never write, but still retire.
- Source mux: ALU → alu_result_i; PC+4 → pc_i + 4 (mod 2^32); IMM → imm_i; LOAD → aligned load data.
- Load alignment: byte = word[8*addr_lo +: 8]; half = word[16*addr_lo[1] +: 16] (addr_lo[0] ignored); LB/LH sign-extend, LBU/LHU zero-extend; LW and the undefined funct3 values 011/110/111 pass the full word.
- FSM states: IDLE, WAIT_LOAD.
  - IDLE, issue_i, wb_sel != LOAD: register write/retire; stay IDLE.
  - IDLE, issue_i, wb_sel = LOAD, mem_rvalid_i = 1: zero-wait load; register write/retire; stay IDLE; no stall.
  - IDLE, issue_i, wb_sel = LOAD, mem_rvalid_i = 0: capture rd, writes_rd, funct3, addr_lo; go WAIT_LOAD.
  - WAIT_LOAD, mem_rvalid_i = 0: stay; issue_i ignored (upstream is held).
  - WAIT_LOAD, mem_rvalid_i = 1: align captured load, register write/retire; go IDLE.
- stall_o = (IDLE & issue_i & wb_sel = LOAD & !mem_rvalid_i) | (WAIT_LOAD & !mem_rvalid_i).
- mem_rvalid_i in IDLE with no load issued: ignored.
- A load to x0, or a load of S/B type, still waits for mem_rvalid_i; it retires with no write.

## Timing
- Reset: state = IDLE, rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, retire_o = 0. stall_o = 0 unless issue_i with a LOAD and no rvalid is presented.
- Reset while in WAIT_LOAD: the pending load is dropped; no write and no retire follow.
- Non-load: rf_we_o/retire_o are high in cycle N+1 for an issue in cycle N.
- Load with rvalid in cycle M (M ≥ N): write/retire in cycle M+1; stall_o is high in cycles N..M-1.
- rf_we_o and retire_o are high for exactly one cycle per instruction. rf_waddr_o/rf_wdata_o hold their last value when rf_we_o = 0.
- The register file writes on the same edge, so a decode read in cycle N+2 sees the value. Same-cycle bypass is the register file's concern.

## Test plan
- Reset, then R-type issue: rd=5, ALU=0x1234 → cycle+1: we=1, waddr=5, wdata=0x00001234, retire=1; cycle+2: we=0.
- JAL with rd=1, pc=0xFFFFFFFC, wb_sel=PC+4 → wdata=0x00000000 (wrap). Same instruction with rd=0 → we=0, retire=1.
- LB with addr_lo=3, word 0x80FF7F01, rvalid 3 cycles after issue → stall high for 3 cycles, then wdata=0xFFFFFF80. LBU with the same inputs → 0x00000080.
- LH with addr_lo=2, word 0x8001_1234, zero-wait rvalid → no stall, wdata=0xFFFF8001. LHU with the same inputs → 0x00008001.
- Reset asserted in the middle of WAIT_LOAD, then rvalid → no write, no retire, state IDLE, stall=0.
- SW/BEQ issue → retire=1, we=0. A stray rvalid in IDLE → no effect.

Source files
------------

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: instruction/result inputs and register-file write port of the writeback stage
interface writeback_unit_if #(parameter int XLEN = 32);
  logic            issue_i;
  logic [2:0]      instr_type_i;
  logic [4:0]      rd_i;
  logic [1:0]      wb_sel_i;
  logic [2:0]      load_funct3_i;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic [1:0]      mem_addr_lo_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_rvalid_i;
  logic            stall_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  logic            retire_o;
  modport master (
    output issue_i, instr_type_i, rd_i, wb_sel_i, load_funct3_i, alu_result_i, pc_i, imm_i,
           mem_addr_lo_i, mem_rdata_i, mem_rvalid_i,
    input  stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, retire_o
  );
  modport slave (
    input  issue_i, instr_type_i, rd_i, wb_sel_i, load_funct3_i, alu_result_i, pc_i, imm_i,
           mem_addr_lo_i, mem_rdata_i, mem_rvalid_i,
    output stall_o, rf_we_o, rf_waddr_o, rf_wdata_o, retire_o
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: selects the result source, waits on load data and drives the registered RF write port
module writeback_unit #(parameter int XLEN = 32) (
  input logic clk_i,
  input logic rst_i,
  writeback_unit_if.slave wb
);
  localparam logic [2:0] TYPER = 3'd0, TYPEI = 3'd1, TYPEU = 3'd4, TYPEJ = 3'd5;
  localparam logic [1:0] SEL_ALU = 2'd0, SEL_LOAD = 2'd1, SEL_PC4 = 2'd2, SEL_IMM = 2'd3;
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t          state_q, state_d;
  logic            pend_we_q, pend_we_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic [2:0]      pend_f3_q, pend_f3_d;
  logic [1:0]      pend_lo_q, pend_lo_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            retire_q, retire_d;
  logic            writes_rd, is_load;
  logic [XLEN-1:0] src;

  // unknown funct3 encodings fall through to the full word
  function automatic logic [XLEN-1:0] align(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    return f3 == 3'b000 ? {{(XLEN-8){b[7]}}, b} :
           f3 == 3'b001 ? {{(XLEN-16){h[15]}}, h} :
           f3 == 3'b100 ? {{(XLEN-8){1'b0}}, b} :
           f3 == 3'b101 ? {{(XLEN-16){1'b0}}, h} : word;
  endfunction

  always_comb begin
    writes_rd  = (wb.instr_type_i inside {TYPER, TYPEI, TYPEU, TYPEJ}) && wb.rd_i != 5'd0;
    is_load    = wb.issue_i && wb.wb_sel_i == SEL_LOAD;
    src        = wb.wb_sel_i == SEL_ALU ? wb.alu_result_i :
                 wb.wb_sel_i == SEL_PC4 ? wb.pc_i + XLEN'(4) :
                 wb.wb_sel_i == SEL_IMM ? wb.imm_i :
                 align(wb.load_funct3_i, wb.mem_addr_lo_i, wb.mem_rdata_i);
    state_d    = state_q;
    pend_we_d  = pend_we_q;
    pend_rd_d  = pend_rd_q;
    pend_f3_d  = pend_f3_q;
    pend_lo_d  = pend_lo_q;
    rf_we_d    = 1'b0;
    retire_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (state_q == IDLE) begin
      if (wb.issue_i && (!is_load || wb.mem_rvalid_i)) begin
        retire_d   = 1'b1;
        rf_we_d    = writes_rd;
        rf_waddr_d = writes_rd ? wb.rd_i : rf_waddr_q;
        rf_wdata_d = writes_rd ? src : rf_wdata_q;
      end else if (is_load) begin
        state_d   = WAIT_LOAD;
        pend_we_d = writes_rd;
        pend_rd_d = wb.rd_i;
        pend_f3_d = wb.load_funct3_i;
        pend_lo_d = wb.mem_addr_lo_i;
      end
    end else if (wb.mem_rvalid_i) begin
      state_d    = IDLE;
      retire_d   = 1'b1;
      rf_we_d    = pend_we_q;
      rf_waddr_d = pend_we_q ? pend_rd_q : rf_waddr_q;
      rf_wdata_d = pend_we_q ? align(pend_f3_q, pend_lo_q, wb.mem_rdata_i) : rf_wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pend_we_q  <= 1'b0;
      pend_rd_q  <= '0;
      pend_f3_q  <= '0;
      pend_lo_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_we_q  <= pend_we_d;
      pend_rd_q  <= pend_rd_d;
      pend_f3_q  <= pend_f3_d;
      pend_lo_q  <= pend_lo_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q   <= retire_d;
    end
  end

  assign wb.stall_o    = state_q == IDLE ? is_load && !wb.mem_rvalid_i : !wb.mem_rvalid_i;
  assign wb.rf_we_o    = rf_we_q;
  assign wb.rf_waddr_o = rf_waddr_q;
  assign wb.rf_wdata_o = rf_wdata_q;
  assign wb.retire_o   = retire_q;
endmodule
